irq_arb: RTL and testbench

- Interrupt controller between the timer/counter peripherals and the CPU core.
- Collects up to 8 level-sensitive peripheral interrupt requests and masks them with a bus-programmable enable register.
- Selects one source, presents its vector to the core, and on core acknowledge returns a one-cycle interrupt-executed pulse to the serviced peripheral.
- Removes the per-peripheral interrupt_request/interrupt_executed point-to-point wiring to the core.

---
 rtl/irq_arb.sv | 154 +++++++++++++++
 tb/tb_irq_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arb.sv
// Interrupt arbiter: masks level requests, grants one source to the core, pulses irq_exec on ack.
// Optional round-robin selection when IRQ_ARB_ROUND_ROBIN_EN is defined (fixed priority otherwise).
module irq_arb #(
    parameter int         N_SRC      = 8,
    parameter int         VEC_W      = 3,
    parameter logic [7:0] IEN_ADDR   = 8'h6f,
    parameter logic [7:0] PEND_ADDR  = 8'h6d,
    parameter int         SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_req,
    output logic [N_SRC-1:0] irq_exec,
    input  logic             sreg_ie,
    output logic             cpu_irq,
    output logic [VEC_W-1:0] cpu_vector,
    input  logic             cpu_ack,
    input  logic             write,
    input  logic             read,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_SRC-1:0] r_ien;
    logic [N_SRC-1:0] r_exec;
    logic [VEC_W-1:0] r_grant;
    logic [VEC_W-1:0] r_vec;
    logic             r_irq;
    logic [1:0]       r_cnt;

    logic [N_SRC-1:0] w_pend;
    logic             w_any;
    logic             w_grant_pend;
    logic [VEC_W-1:0] w_winner;

    // Lowest index wins.
    function automatic logic [VEC_W-1:0] f_fixed_winner(input logic [N_SRC-1:0] pend);
        logic [VEC_W-1:0] w;
        w = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) w = VEC_W'(i);
        end
        return w;
    endfunction

    assign w_pend       = irq_req & r_ien;
    assign w_any        = |w_pend;
    assign w_grant_pend = w_pend[r_grant];

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [VEC_W-1:0] r_rr_ptr;
    logic [VEC_W-1:0] w_rr_next;

    // First pending source at or after ptr, wrapping modulo N_SRC.
    function automatic logic [VEC_W-1:0] f_rr_winner(input logic [N_SRC-1:0] pend,
                                                     input logic [VEC_W-1:0] ptr);
        logic [VEC_W-1:0] w;
        int               idx;
        w = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_SRC;
            if (pend[idx]) w = VEC_W'(idx);
        end
        return w;
    endfunction

    assign w_winner  = f_rr_winner(w_pend, r_rr_ptr);
    assign w_rr_next = (int'(r_grant) == N_SRC - 1) ? '0 : r_grant + 1'b1;

    // Pointer only advances on a serviced interrupt; withdraws leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_REQ && cpu_ack) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`else
    assign w_winner = f_fixed_winner(w_pend);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ien   <= '0;
            r_exec  <= '0;
            r_grant <= '0;
            r_vec   <= '0;
            r_irq   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_exec <= '0;
            if (write && addr == IEN_ADDR) begin
                r_ien <= wdata[N_SRC-1:0];
            end
            case (r_state)
                ST_IDLE: begin
                    if (sreg_ie && w_any) begin
                        r_grant <= w_winner;
                        r_vec   <= w_winner;
                        r_irq   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over a simultaneous withdraw.
                    if (cpu_ack) begin
                        r_irq   <= 1'b0;
                        r_exec  <= N_SRC'(1) << r_grant;
                        r_cnt   <= 2'(SETTLE_CYC);
                        r_state <= ST_SETTLE;
                    end else if (!w_grant_pend || !sreg_ie) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // Gives the peripheral time to drop its registered request.
                    if (r_cnt <= 2'd1) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (read) begin
            if (addr == IEN_ADDR) begin
                rdata = 8'(r_ien);
            end else if (addr == PEND_ADDR) begin
                rdata = 8'(w_pend);
            end
        end
    end

    assign irq_exec   = r_exec;
    assign cpu_irq    = r_irq;
    assign cpu_vector = r_vec;

endmodule

// File: tb/tb_irq_arb.sv
// Self-checking bench for irq_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural owner/quiet-time model.
module tb_irq_arb;

    localparam int SETTLE = 3;

    logic       clk;
    logic       rst;
    logic [7:0] irq_req;
    logic [7:0] irq_exec;
    logic       sreg_ie;
    logic       cpu_irq;
    logic [2:0] cpu_vector;
    logic       cpu_ack;
    logic       write;
    logic       read;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    irq_arb #(
        .N_SRC(8), .VEC_W(3), .IEN_ADDR(8'h6f), .PEND_ADDR(8'h6d), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .irq_exec(irq_exec), .sreg_ie(sreg_ie),
        .cpu_irq(cpu_irq), .cpu_vector(cpu_vector), .cpu_ack(cpu_ack), .write(write),
        .read(read), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who currently owns the core (-1 = nobody) and how many cycles
    // must pass before a new arbitration may happen.
    int         m_owner = -1;
    int         m_quiet = 0;
    int         m_rr    = 0;
    logic [7:0] m_ien   = 8'h00;
    logic       m_irq   = 1'b0;
    logic [2:0] m_vec   = 3'd0;
    logic [7:0] m_exec  = 8'h00;

    function automatic int pick_winner(input logic [7:0] pend, input int ptr);
        int w;
        w = -1;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 8; k++)
            if (w < 0 && pend[(ptr + k) % 8]) w = (ptr + k) % 8;
`else
        for (int i = 0; i < 8; i++)
            if (w < 0 && pend[i]) w = i;
`endif
        return w;
    endfunction

    function automatic logic [7:0] exp_rdata();
        if (!read) return 8'h00;
        if (addr == 8'h6f) return m_ien;
        if (addr == 8'h6d) return irq_req & m_ien;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        logic [7:0] pend;
        pend = irq_req & m_ien;
        m_exec = 8'h00;
        if (rst) begin
            m_owner = -1; m_quiet = 0; m_rr = 0; m_ien = 8'h00;
            m_irq = 1'b0; m_vec = 3'd0;
        end else begin
            if (m_owner >= 0) begin
                if (cpu_ack) begin
                    m_exec  = 8'h01 << m_owner;
                    m_rr    = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_quiet = SETTLE;
                    m_irq   = 1'b0;
                end else if (!pend[m_owner] || !sreg_ie) begin
                    m_owner = -1;
                    m_irq   = 1'b0;
                end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if (sreg_ie && pend != 8'h00) begin
                m_owner = pick_winner(pend, m_rr);
                m_vec   = 3'(m_owner);
                m_irq   = 1'b1;
            end
            if (write && addr == 8'h6f) m_ien = wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_cpu_irq", 32'(cpu_irq), 32'(m_irq));
            chk("cyc_cpu_vector", 32'(cpu_vector), 32'(m_vec));
            chk("cyc_irq_exec", 32'(irq_exec), 32'(m_exec));
            chk("cyc_rdata", 32'(rdata), 32'(exp_rdata()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        write = 1'b1; addr = a; wdata = d;
        step(1);
        write = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        read = 1'b1; addr = a;
        #1;
        chk(name, 32'(rdata), 32'(exp));
        read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_req = 8'h00; sreg_ie = 1'b0; cpu_ack = 1'b0;
        write = 1'b0; read = 1'b0; addr = 8'h00; wdata = 8'h00;
        step(2);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        chk("rst_irq_exec", 32'(irq_exec), 32'd0);
        chk("rst_vector", 32'(cpu_vector), 32'd0);
        read_chk("rst_ien", 8'h6f, 8'h00);

        // Basic grant / ack.
        bus_write(8'h6f, 8'h05);
        read_chk("ien_rd", 8'h6f, 8'h05);
        irq_req = 8'h04; sreg_ie = 1'b1;
        step(1);
        chk("basic_irq", 32'(cpu_irq), 32'd1);
        chk("basic_vec", 32'(cpu_vector), 32'd2);
        read_chk("basic_pend", 8'h6d, 8'h04);
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0; irq_req = 8'h00;
        chk("basic_exec", 32'(irq_exec), 32'h04);
        chk("basic_irq_lo", 32'(cpu_irq), 32'd0);
        step(1);
        chk("basic_exec_1cyc", 32'(irq_exec), 32'h00);
        step(5);

        // Two sources, priority order and settle spacing.
        bus_write(8'h6f, 8'hFF);
        irq_req = 8'h0A;
        step(1);
`ifndef IRQ_ARB_ROUND_ROBIN_EN
        chk("prio_first", 32'(cpu_vector), 32'd1);
`endif
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0;
`ifndef IRQ_ARB_ROUND_ROBIN_EN
        irq_req = 8'h08;
        chk("prio_exec", 32'(irq_exec), 32'h02);
        step(3);
        chk("settle_quiet", 32'(cpu_irq), 32'd0);
        step(1);
        chk("settle_reassert", 32'(cpu_irq), 32'd1);
        chk("prio_second", 32'(cpu_vector), 32'd3);
`else
        step(4);
`endif
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0; irq_req = 8'h00;
        step(6);

        // No re-arbitration while in REQ.
        irq_req = 8'h04;
        step(1);
        chk("hold_first", 32'(cpu_vector), 32'd2);
        irq_req = 8'h05;
        step(2);
        chk("hold_irq", 32'(cpu_irq), 32'd1);
        chk("hold_vec", 32'(cpu_vector), 32'd2);
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0; irq_req = 8'h01;
        chk("hold_exec", 32'(irq_exec), 32'h04);
        step(4);
        chk("hold_after", 32'(cpu_vector), 32'd0);
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0; irq_req = 8'h00;
        step(6);

        // Withdraw versus ack in the same cycle.
        irq_req = 8'h02;
        step(1);
        chk("wd_irq", 32'(cpu_irq), 32'd1);
        irq_req = 8'h00;
        step(1);
        chk("wd_irq_lo", 32'(cpu_irq), 32'd0);
        chk("wd_no_exec", 32'(irq_exec), 32'h00);
        irq_req = 8'h02;
        step(1);
        irq_req = 8'h00; cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0;
        chk("wd_ack_wins", 32'(irq_exec), 32'h02);
        step(6);

        // Reset while in REQ drops everything, including a late ack.
        irq_req = 8'h01;
        step(1);
        chk("rstreq_irq", 32'(cpu_irq), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rstreq_irq_lo", 32'(cpu_irq), 32'd0);
        chk("rstreq_exec", 32'(irq_exec), 32'h00);
        read_chk("rstreq_ien", 8'h6f, 8'h00);
        cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0;
        chk("rstreq_late_ack", 32'(irq_exec), 32'h00);
        irq_req = 8'h00;
        step(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irq_req = 8'($urandom);
            sreg_ie = ($urandom_range(0, 15) != 0);
            write   = ($urandom_range(0, 19) == 0);
            wdata   = 8'($urandom);
            read    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       addr = 8'h6f;
                1:       addr = 8'h6d;
                default: addr = 8'($urandom);
            endcase
            cpu_ack = ($urandom_range(0, 2) == 0);
            step(1);
        end
        rst = 1'b0; write = 1'b0; read = 1'b0; cpu_ack = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
